// File: rtl/seq_detect_mealy_cfg.sv
// seq_detect_mealy_cfg
// Run-time programmable serial pattern detector (1..MAX_LEN bits) with a
// registered Mealy match pulse, an armed flag, overlap/non-overlap modes,
// a bit-valid qualifier and an enable.
// Optional build macro SEQ_DETECT_MATCH_COUNT_EN adds a saturating 16-bit
// match counter (match_count output, count_clr input).

module seq_detect_mealy_cfg #(
  parameter int                 MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1001,
  parameter int                 RST_LEN     = 4,
  parameter logic               RST_OVERLAP = 1'b1,
  parameter int                 LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  output logic               dout,
  output logic               armed
`ifdef SEQ_DETECT_MATCH_COUNT_EN
  ,
  input  logic               count_clr,
  output logic [15:0]        match_count
`endif
);

  // Detector states; derived from fill/len/en rather than stored.
  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_FILL     = 2'd1;
  localparam logic [1:0] ST_HUNT     = 2'd2;

  localparam logic [LW-1:0] ONE_LW     = LW'(1);
  localparam logic [LW-1:0] ZERO_LW    = LW'(0);
  localparam logic [LW-1:0] MAX_LEN_LW = LW'(MAX_LEN);
  localparam logic [LW-1:0] RST_LEN_LW = LW'(RST_LEN);

  // Configuration registers
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]      len_q, len_d;
  logic               overlap_q, overlap_d;

  // History keeps only MAX_LEN-1 bits: together with the incoming bit that
  // covers the longest pattern, and the oldest shifted-out bit is never
  // compared against anything.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic               dout_q, dout_d;
  logic               armed_q, armed_d;

  // Combinational helpers
  logic               len_ok_s;
  logic [LW-1:0]      len_m1_s;
  logic [31:0]        len_ext_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [MAX_LEN-1:0] shifted_s;
  logic [1:0]         state_s;
  logic               match_s;
  logic               len_ok_d_s;

  assign len_ok_s  = (len_q != ZERO_LW) && (len_q <= MAX_LEN_LW);
  assign len_m1_s  = len_q - ONE_LW;
  assign len_ext_s = {{(32-LW){1'b0}}, len_q};
  assign shifted_s = {hist_q, din};

  // Mask selecting the low len bits of pattern and history.
  always_comb begin
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (32'(i) < len_ext_s) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // Current detector state from enable, length validity and fill level.
  always_comb begin
    if (!en || !len_ok_s) begin
      state_s = ST_DISABLED;
    end else if (fill_q < len_m1_s) begin
      state_s = ST_FILL;
    end else begin
      state_s = ST_HUNT;
    end
  end

  // Match when hunting and the low len bits of {hist,din} equal the pattern;
  // for len=1 the mask reduces this to din == pattern[0].
  always_comb begin
    if (state_s == ST_HUNT) begin
      match_s = (((shifted_s ^ pattern_q) & mask_s) == {MAX_LEN{1'b0}});
    end else begin
      match_s = 1'b0;
    end
  end

  // Next-state: config load beats a valid bit; otherwise shift on valid bits.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    dout_d    = 1'b0;
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = {(MAX_LEN-1){1'b0}};
      fill_d    = ZERO_LW;
      dout_d    = 1'b0;
    end else if ((state_s != ST_DISABLED) && din_valid) begin
      hist_d = shifted_s[MAX_LEN-2:0];
      dout_d = match_s;
      if (match_s && !overlap_q) begin
        // Non-overlapping: demand a completely fresh pattern.
        fill_d = ZERO_LW;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + ONE_LW;
      end else begin
        fill_d = len_q;
      end
    end else begin
      dout_d = 1'b0;
    end
  end

  // Armed looks ahead: next fill against the next (possibly new) length.
  always_comb begin
    len_ok_d_s = (len_d != ZERO_LW) && (len_d <= MAX_LEN_LW);
    if (len_ok_d_s) begin
      armed_d = (fill_d >= (len_d - ONE_LW));
    end else begin
      armed_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset to the RST_* config.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= RST_PATTERN;
      len_q     <= RST_LEN_LW;
      overlap_q <= RST_OVERLAP;
      hist_q    <= {(MAX_LEN-1){1'b0}};
      fill_q    <= ZERO_LW;
      dout_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      dout_q    <= dout_d;
      armed_q   <= armed_d;
    end
  end

  assign dout  = dout_q;
  assign armed = armed_q;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  logic [15:0] count_q, count_d;

  // Saturating match counter; clear has priority over an increment.
  always_comb begin
    if (count_clr) begin
      count_d = 16'h0000;
    end else if (dout_d && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'h0001;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register; configuration loads deliberately leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_seq_detect_mealy_cfg.sv
// Directed bench for seq_detect_mealy_cfg (default MAX_LEN=8 build).
module tb_seq_detect_mealy_cfg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_overlap = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       dout;
  logic       armed;
`ifdef SEQ_DETECT_MATCH_COUNT_EN
  logic        count_clr = 1'b0;
  logic [15:0] match_count;
`endif

  int total = 0;
  int passed = 0;
  int fails = 0;

  seq_detect_mealy_cfg dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din_valid   (din_valid),
    .din         (din),
    .dout        (dout),
    .armed       (armed)
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    ,
    .count_clr   (count_clr),
    .match_count (match_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given valid/data, sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input logic d);
    din_valid = v;
    din = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic bit_chk(input string tag, input logic d, input logic exp_dout, input logic exp_armed);
    cyc(1'b1, d);
    chk({tag, ".dout"}, {15'd0, dout}, {15'd0, exp_dout});
    chk({tag, ".armed"}, {15'd0, armed}, {15'd0, exp_armed});
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = ov;
    cfg_we = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    din_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dout", {15'd0, dout}, 16'd0);
    chk("rst.armed", {15'd0, armed}, 16'd0);
    reset = 1'b0;

    // Default config: 1001, overlap -> pulses after bits 4 and 7
    bit_chk("t1.b1", 1'b1, 1'b0, 1'b0);
    bit_chk("t1.b2", 1'b0, 1'b0, 1'b0);
    bit_chk("t1.b3", 1'b0, 1'b0, 1'b1);
    bit_chk("t1.b4", 1'b1, 1'b1, 1'b1);
    bit_chk("t1.b5", 1'b0, 1'b0, 1'b1);
    bit_chk("t1.b6", 1'b0, 1'b0, 1'b1);
    bit_chk("t1.b7", 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    chk("t1.idle.dout", {15'd0, dout}, 16'd0);

    // Non-overlap: only the first occurrence
    load(8'b0000_1001, 4'd4, 1'b0);
    chk("t2.cfg.armed", {15'd0, armed}, 16'd0);
    bit_chk("t2.b1", 1'b1, 1'b0, 1'b0);
    bit_chk("t2.b2", 1'b0, 1'b0, 1'b0);
    bit_chk("t2.b3", 1'b0, 1'b0, 1'b1);
    bit_chk("t2.b4", 1'b1, 1'b1, 1'b0);
    bit_chk("t2.b5", 1'b0, 1'b0, 1'b0);
    bit_chk("t2.b6", 1'b0, 1'b0, 1'b0);
    bit_chk("t2.b7", 1'b1, 1'b0, 1'b1);

    // Gaps in din_valid between bits 2 and 3
    load(8'b0000_1001, 4'd4, 1'b1);
    bit_chk("t3.b1", 1'b1, 1'b0, 1'b0);
    bit_chk("t3.b2", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      chk("t3.gap.dout", {15'd0, dout}, 16'd0);
    end
    bit_chk("t3.b3", 1'b0, 1'b0, 1'b1);
    bit_chk("t3.b4", 1'b1, 1'b1, 1'b1);

    // Reload mid-stream with a coincident valid bit that must be dropped
    load(8'b0000_1001, 4'd4, 1'b1);
    bit_chk("t4.s1", 1'b1, 1'b0, 1'b0);
    bit_chk("t4.s2", 1'b0, 1'b0, 1'b0);
    bit_chk("t4.s3", 1'b0, 1'b0, 1'b1);
    bit_chk("t4.s4", 1'b1, 1'b1, 1'b1);
    bit_chk("t4.s5", 1'b0, 1'b0, 1'b1);
    din_valid = 1'b1;
    din = 1'b1;
    load(8'b1011_0110, 4'd8, 1'b1);
    chk("t4.cfg.dout", {15'd0, dout}, 16'd0);
    chk("t4.cfg.armed", {15'd0, armed}, 16'd0);
    bit_chk("t4.f1", 1'b1, 1'b0, 1'b0);
    bit_chk("t4.f2", 1'b0, 1'b0, 1'b0);
    bit_chk("t4.f3", 1'b1, 1'b0, 1'b0);
    bit_chk("t4.f4", 1'b1, 1'b0, 1'b0);
    bit_chk("t4.f5", 1'b0, 1'b0, 1'b0);
    bit_chk("t4.f6", 1'b1, 1'b0, 1'b0);
    bit_chk("t4.f7", 1'b1, 1'b0, 1'b1);
    bit_chk("t4.f8", 1'b0, 1'b1, 1'b1);

    // len=1 with junk in the ignored upper pattern bits
    load(8'b1111_1101, 4'd1, 1'b1);
    chk("t5.cfg.armed", {15'd0, armed}, 16'd1);
    bit_chk("t5.b1", 1'b1, 1'b1, 1'b1);
    bit_chk("t5.b2", 1'b1, 1'b1, 1'b1);
    bit_chk("t5.b3", 1'b0, 1'b0, 1'b1);
    bit_chk("t5.b4", 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("t5.idle.dout", {15'd0, dout}, 16'd0);

    // len=0 and len>MAX_LEN disable the detector
    load(8'b0000_0001, 4'd0, 1'b1);
    chk("t6.len0.armed", {15'd0, armed}, 16'd0);
    for (int i = 0; i < 6; i++) begin
      bit_chk("t6.len0", 1'b1, 1'b0, 1'b0);
    end
    load(8'b0000_0000, 4'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bit_chk("t6.len9", 1'b0, 1'b0, 1'b0);
    end

    // en=0 holds history and suppresses matches
    load(8'b0000_1001, 4'd4, 1'b1);
    bit_chk("t7.b1", 1'b1, 1'b0, 1'b0);
    bit_chk("t7.b2", 1'b0, 1'b0, 1'b0);
    bit_chk("t7.b3", 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    bit_chk("t7.dis", 1'b1, 1'b0, 1'b1);
    en = 1'b1;
    bit_chk("t7.b4", 1'b1, 1'b1, 1'b1);

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    // Counter: three matches, clear beats a coincident match, saturation
    load(8'b0000_0001, 4'd1, 1'b1);
    count_clr = 1'b1;
    cyc(1'b0, 1'b0);
    count_clr = 1'b0;
    chk("t8.clr", match_count, 16'd0);
    bit_chk("t8.m1", 1'b1, 1'b1, 1'b1);
    bit_chk("t8.m2", 1'b1, 1'b1, 1'b1);
    bit_chk("t8.m3", 1'b1, 1'b1, 1'b1);
    chk("t8.cnt3", match_count, 16'd3);
    count_clr = 1'b1;
    bit_chk("t8.clrm", 1'b1, 1'b1, 1'b1);
    count_clr = 1'b0;
    chk("t8.clrprio", match_count, 16'd0);
    din_valid = 1'b1;
    din = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    din_valid = 1'b0;
    chk("t8.sat", match_count, 16'hFFFF);
`endif

    // Asynchronous reset mid-stream
    load(8'b0000_0001, 4'd1, 1'b1);
    bit_chk("t9.pre", 1'b1, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t9.async.dout", {15'd0, dout}, 16'd0);
    chk("t9.async.armed", {15'd0, armed}, 16'd0);
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    chk("t9.async.cnt", match_count, 16'd0);
`endif
    #2;
    reset = 1'b0;
    // Configuration reverted to the reset pattern 1001
    bit_chk("t9.b1", 1'b1, 1'b0, 1'b0);
    bit_chk("t9.b2", 1'b0, 1'b0, 1'b0);
    bit_chk("t9.b3", 1'b0, 1'b0, 1'b1);
    bit_chk("t9.b4", 1'b1, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
